// File: rtl/fir_ctrl_fsm.sv
// fir_ctrl_fsm: sequences coefficient load, FIR filtering into the FIFO, full hold and UART drain.
// Push-buttons are synchronised and edge-detected locally; the coefficient counter lives here too.
module fir_ctrl_fsm #(
    parameter int NUM_COEF     = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int AUTO_RESTART = 0,
    localparam int AW          = $clog2(NUM_COEF)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          btn_load_i,
    input  logic          btn_send_i,
    input  logic          coef_valid_i,
    input  logic          sample_valid_i,
    input  logic          fifo_full_i,
    input  logic          fifo_empty_i,
    input  logic          tx_ready_i,
    output logic          en_recepcion_o,
    output logic          coef_we_o,
    output logic [AW-1:0] coef_addr_o,
    output logic          coef_loaded_o,
    output logic          en_fir_o,
    output logic          fifo_wr_o,
    output logic          fifo_rd_o,
    output logic          led_full_o,
    output logic          overflow_o,
    output logic [2:0]    state_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, FILTER = 3'd2, FULL = 3'd3, SEND = 3'd4} state_t;

    state_t st, st_n;
    logic [SYNC_STAGES-1:0] l_sync, s_sync;
    logic l_prev, s_prev, l_pulse, s_pulse;
    logic [AW-1:0] cnt, cnt_n;
    logic loaded_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l_sync  <= '0;
            s_sync  <= '0;
            l_prev  <= 1'b0;
            s_prev  <= 1'b0;
            l_pulse <= 1'b0;
            s_pulse <= 1'b0;
        end else begin
            l_sync  <= {l_sync[SYNC_STAGES-2:0], btn_load_i};
            s_sync  <= {s_sync[SYNC_STAGES-2:0], btn_send_i};
            l_prev  <= l_sync[SYNC_STAGES-1];
            s_prev  <= s_sync[SYNC_STAGES-1];
            l_pulse <= l_sync[SYNC_STAGES-1] & ~l_prev;
            s_pulse <= s_sync[SYNC_STAGES-1] & ~s_prev;
        end
    end

    // A load pulse overrides everything, including a simultaneous send pulse or coefficient.
    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        loaded_n = coef_loaded_o;
        if (l_pulse) begin
            st_n     = LOAD;
            cnt_n    = '0;
            loaded_n = 1'b0;
        end else begin
            case (st)
                IDLE:    st_n = (s_pulse && coef_loaded_o) ? FILTER : IDLE;
                LOAD: begin
                    if (coef_valid_i) begin
                        if (cnt == AW'(NUM_COEF - 1)) begin
                            st_n     = FILTER;
                            cnt_n    = '0;
                            loaded_n = 1'b1;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                FILTER:  st_n = fifo_full_i ? FULL : FILTER;
                FULL:    st_n = s_pulse ? SEND : FULL;
                SEND:    st_n = fifo_empty_i ? ((AUTO_RESTART != 0) ? FILTER : IDLE) : SEND;
                default: st_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st             <= IDLE;
            cnt            <= '0;
            coef_loaded_o  <= 1'b0;
            overflow_o     <= 1'b0;
            en_recepcion_o <= 1'b0;
            en_fir_o       <= 1'b0;
            led_full_o     <= 1'b0;
        end else begin
            st             <= st_n;
            cnt            <= cnt_n;
            coef_loaded_o  <= loaded_n;
            overflow_o     <= overflow_o | ((st == FILTER) & sample_valid_i & fifo_full_i);
            en_recepcion_o <= st == LOAD;
            en_fir_o       <= st == FILTER;
            led_full_o     <= st == FULL;
        end
    end

    assign coef_we_o   = (st == LOAD) & coef_valid_i;
    assign coef_addr_o = (st == LOAD) ? cnt : '0;
    assign fifo_wr_o   = (st == FILTER) & sample_valid_i & ~fifo_full_i;
    assign fifo_rd_o   = (st == SEND) & tx_ready_i & ~fifo_empty_i;
    assign state_o     = st;
endmodule
